// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the multiply/divide sequencing control unit.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ABS,
      S_MUL_ITER,
      S_DIV_ITER,
      S_DIV_FIX,
      S_SIGN_FIX,
      S_DONE
   } state_e;

   localparam logic [1:0] RES_LO   = 2'd0;
   localparam logic [1:0] RES_HI   = 2'd1;
   localparam logic [1:0] RES_QUOT = 2'd2;
   localparam logic [1:0] RES_REM  = 2'd3;

   function automatic logic is_div(input op_e op);
      return op[2];
   endfunction

   function automatic logic is_signed_div(input op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_rem(input op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic [1:0] res_sel(input op_e op);
      if (is_div(op)) return is_rem(op) ? RES_REM : RES_QUOT;
      return (op == OP_MUL) ? RES_LO : RES_HI;
   endfunction

endpackage

// File: rtl/mdu_iter_counter.sv
// Iteration counter: synchronous clear, count enable, saturates at a runtime terminal limit.
module mdu_iter_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] cnt;

   assign tc = (cnt == limit);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (en && !tc) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/mult_div_unit_cu.sv
// Sequencer for the Booth multiply / restoring divide datapath with start/busy/done handshake.
module mult_div_unit_cu
   import mdu_pkg::*;
#(
   parameter int parallelism = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] opCode,
   input  logic [1:0] boothPair,
   input  logic       remNeg,
   input  logic       divZero,
   input  logic       lSign,
   input  logic       rSign,
   output logic       busy,
   output logic       done,
   output logic       opLoad,
   output logic       absEn,
   output logic       accAdd,
   output logic       accSub,
   output logic       shiftEn,
   output logic       quotBit,
   output logic       restoreEn,
   output logic       negQuot,
   output logic       negRem,
   output logic [1:0] resSel,
   output logic       zeroSel
);

   localparam int CW = $clog2(parallelism + 2);
   localparam logic [CW-1:0] LIM_MUL = CW'(parallelism);
   localparam logic [CW-1:0] LIM_DIV = CW'(parallelism - 1);

   state_e state;
   state_e nxt;
   op_e    op_q;
   logic   tc;

   mdu_iter_counter #(.W(CW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (state == S_LOAD),
      .en    ((state == S_MUL_ITER) || (state == S_DIV_ITER)),
      .limit (is_div(op_q) ? LIM_DIV : LIM_MUL),
      .tc    (tc)
   );

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:     if (start) nxt = S_LOAD;
         S_LOAD: begin
            if (!is_div(op_q))  nxt = S_MUL_ITER;
            else if (divZero)   nxt = S_DONE;
            else                nxt = S_ABS;
         end
         S_ABS:      nxt = S_DIV_ITER;
         S_MUL_ITER: if (tc) nxt = S_DONE;
         S_DIV_ITER: if (tc) nxt = S_DIV_FIX;
         S_DIV_FIX:  nxt = S_SIGN_FIX;
         S_SIGN_FIX: nxt = S_DONE;
         S_DONE:     nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
   end

   // State-only outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         op_q    <= OP_MUL;
         busy    <= 1'b0;
         done    <= 1'b0;
         opLoad  <= 1'b0;
         absEn   <= 1'b0;
         shiftEn <= 1'b0;
         negQuot <= 1'b0;
         negRem  <= 1'b0;
         resSel  <= RES_LO;
         zeroSel <= 1'b0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && start) op_q <= op_e'(opCode);
         busy    <= (nxt != S_IDLE);
         done    <= (nxt == S_DONE);
         opLoad  <= (nxt == S_LOAD);
         absEn   <= (nxt == S_ABS) && is_signed_div(op_q);
         shiftEn <= (nxt == S_MUL_ITER) || (nxt == S_DIV_ITER);
         negQuot <= (nxt == S_SIGN_FIX) && (op_q == OP_DIV) && (lSign ^ rSign);
         negRem  <= (nxt == S_SIGN_FIX) && (op_q == OP_REM) && lSign;
         resSel  <= (nxt == S_DONE) ? res_sel(op_q) : RES_LO;
         zeroSel <= (state == S_LOAD) && (nxt == S_DONE);
      end
   end

   // Only these strobes follow the datapath status combinationally.
   assign accAdd    = (state == S_MUL_ITER) && (boothPair == 2'b01);
   assign accSub    = ((state == S_MUL_ITER) && (boothPair == 2'b10)) || (state == S_DIV_ITER);
   assign quotBit   = (state == S_DIV_ITER) && !remNeg;
   assign restoreEn = ((state == S_DIV_ITER) || (state == S_DIV_FIX)) && remNeg;

endmodule

// File: tb/tb_mult_div_unit_cu.sv
// Directed bench for mult_div_unit_cu with a small Booth / restoring-divide datapath model.
module tb_mult_div_unit_cu;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] opCode;
   logic [1:0] boothPair;
   logic       remNeg;
   logic       divZero;
   logic       lSign;
   logic       rSign;
   logic       busy, done, opLoad, absEn, accAdd, accSub, shiftEn;
   logic       quotBit, restoreEn, negQuot, negRem, zeroSel;
   logic [1:0] resSel;

   int checks = 0;
   int errors = 0;

   mult_div_unit_cu #(.parallelism(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .opCode    (opCode),
      .boothPair (boothPair),
      .remNeg    (remNeg),
      .divZero   (divZero),
      .lSign     (lSign),
      .rSign     (rSign),
      .busy      (busy),
      .done      (done),
      .opLoad    (opLoad),
      .absEn     (absEn),
      .accAdd    (accAdd),
      .accSub    (accSub),
      .shiftEn   (shiftEn),
      .quotBit   (quotBit),
      .restoreEn (restoreEn),
      .negQuot   (negQuot),
      .negRem    (negRem),
      .resSel    (resSel),
      .zeroSel   (zeroSel)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] outs();
      return {busy, done, opLoad, absEn, accAdd, accSub, shiftEn, quotBit,
              restoreEn, negQuot, negRem, resSel, zeroSel};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Booth multiply: multiplicand m, multiplier q; returns low 32 product bits assembled from DUT strobes.
   task automatic run_mul(input logic [2:0] op, input logic signed [32:0] m,
                          input logic signed [32:0] q, input logic [1:0] exp_sel,
                          input logic [31:0] exp_lo);
      logic signed [32:0] a;
      logic [32:0] mq;
      logic m1;
      int bad, busy_cnt;
      a = '0; mq = q; m1 = 1'b0; bad = 0; busy_cnt = 0;
      start = 1'b1; opCode = op;
      tick(); start = 1'b0; #1;
      chk("mul_load", {busy, opLoad, shiftEn}, 3'b110);
      busy_cnt += busy;
      for (int k = 2; k <= 34; k++) begin
         tick(); boothPair = {mq[0], m1}; #1;
         if (accAdd !== (boothPair == 2'b01) || accSub !== (boothPair == 2'b10) ||
             shiftEn !== 1'b1 || done !== 1'b0) bad++;
         busy_cnt += busy;
         if (accAdd) a = a + m;
         if (accSub) a = a - m;
         if (shiftEn) {a, mq, m1} = {a[32], a, mq};
      end
      chk("mul_booth_strobes", bad, 0);
      chk("mul_product_lo", mq[31:0], exp_lo);
      tick(); boothPair = 2'b00; #1;
      busy_cnt += busy;
      chk("mul_done", {done, resSel, shiftEn}, {1'b1, exp_sel, 1'b0});
      chk("mul_busy_cycles", busy_cnt, 35);
      tick(); #1;
      chk("mul_idle_after", {busy, done}, 2'b00);
   endtask

   // Restoring divide on magnitudes n/d; DUT quotBit/restoreEn build the quotient and remainder.
   task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] n,
                          input logic [31:0] d, input logic ls, input logic rs,
                          input logic exp_abs, input logic exp_nq, input logic exp_nr,
                          input logic fix_neg, input logic [1:0] exp_sel,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic poke);
      longint r, t;
      logic [31:0] qacc;
      int bad;
      r = 0; qacc = '0; bad = 0;
      start = 1'b1; opCode = op; lSign = ls; rSign = rs; divZero = 1'b0;
      tick(); start = 1'b0; #1;
      chk({tag, "_load"}, {busy, opLoad, absEn}, 3'b110);
      tick(); #1;
      chk({tag, "_abs"}, {absEn, shiftEn, accSub}, {exp_abs, 2'b00});
      for (int i = 31; i >= 0; i--) begin
         tick();
         if (poke && i == 24) begin start = 1'b1; opCode = 3'b000; end
         else begin start = 1'b0; opCode = op; end
         r = (r << 1) | longint'(n[i]);
         t = r - longint'(d);
         remNeg = (t < 0);
         #1;
         if (accSub !== 1'b1 || shiftEn !== 1'b1 || quotBit !== !remNeg ||
             restoreEn !== remNeg || done !== 1'b0 || accAdd !== 1'b0) bad++;
         qacc = {qacc[30:0], quotBit};
         r = t;
         if (restoreEn) r = r + longint'(d);
      end
      start = 1'b0;
      chk({tag, "_iter_strobes"}, bad, 0);
      chk({tag, "_quot_mag"}, qacc, exp_q);
      chk({tag, "_rem_mag"}, r[31:0], exp_r);
      tick(); remNeg = fix_neg; #1;
      chk({tag, "_fix"}, {restoreEn, shiftEn, accSub, done}, {fix_neg, 3'b000});
      tick(); remNeg = 1'b0; #1;
      chk({tag, "_sign_fix"}, {negQuot, negRem, done}, {exp_nq, exp_nr, 1'b0});
      tick(); #1;
      chk({tag, "_done"}, {done, resSel, zeroSel, busy}, {1'b1, exp_sel, 1'b0, 1'b1});
      tick(); #1;
      chk({tag, "_idle_after"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int dcnt;
      int dpos[$];
      logic saw_done;
      rst = 1'b1; start = 1'b0; opCode = 3'b000; boothPair = 2'b00;
      remNeg = 1'b0; divZero = 1'b0; lSign = 1'b0; rSign = 1'b0;
      tick(); tick(); #1;
      chk("reset_outputs", outs(), 14'h0);
      tick(); rst = 1'b0; #1;
      chk("idle_outputs", outs(), 14'h0);

      // MUL 7 x -3 and MULHU with a different multiplier pattern.
      tick(); run_mul(3'b000, 33'sd7, -33'sd3, 2'd0, 32'hFFFF_FFEB);
      tick(); run_mul(3'b011, 33'sd5, 33'sd6, 2'd1, 32'd30);

      // DIV -20/3 with a stray start mid-flight, then REM -20/3.
      tick(); run_div("div", 3'b100, 32'd20, 32'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                      1'b0, 2'd2, 32'd6, 32'd2, 1'b1);
      tick(); run_div("rem", 3'b110, 32'd20, 32'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                      1'b1, 2'd3, 32'd6, 32'd2, 1'b0);
      // Overflow case: magnitudes 0x80000000 / 1, signs equal so no negate.
      tick(); run_div("ovf", 3'b100, 32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                      1'b0, 2'd2, 32'h8000_0000, 32'd0, 1'b0);
      tick(); run_div("divu", 3'b101, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b0, 2'd2, 32'd14, 32'd2, 1'b0);
      lSign = 1'b0; rSign = 1'b0;

      // DIVU by zero: short path straight to DONE.
      tick(); start = 1'b1; opCode = 3'b101;
      tick(); start = 1'b0; divZero = 1'b1; #1;
      chk("dz_load", {opLoad, busy}, 2'b11);
      tick(); #1;
      chk("dz_done", {done, zeroSel, resSel, absEn, shiftEn, accSub},
          {1'b1, 1'b1, 2'd2, 3'b000});
      tick(); divZero = 1'b0; #1;
      chk("dz_idle_after", {busy, done, zeroSel}, 3'b000);

      // Reset at MUL iteration 10 abandons the operation.
      tick(); start = 1'b1; opCode = 3'b000;
      for (int k = 1; k <= 11; k++) begin tick(); start = 1'b0; end
      boothPair = 2'b01; rst = 1'b1;
      tick(); #1;
      chk("rst_mid_mul", outs(), 14'h0);
      rst = 1'b0; saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin tick(); #1; if (done) saw_done = 1'b1; end
      chk("rst_no_done", {saw_done, busy}, 2'b00);
      boothPair = 2'b00;

      // start held high: one MUL every 36 cycles.
      tick(); start = 1'b1; opCode = 3'b000; dcnt = 0;
      for (int k = 1; k <= 110; k++) begin
         tick(); #1;
         if (done) begin dcnt++; dpos.push_back(k); end
      end
      start = 1'b0;
      chk("held_done_count", dcnt, 3);
      if (dpos.size() == 3) begin
         chk("held_done_0", dpos[0], 35);
         chk("held_done_1", dpos[1], 71);
         chk("held_done_2", dpos[2], 107);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit_cu.md
# mult_div_unit_cu

Sequencing control unit for the multiply/divide datapath. Accepts one operation at a time through a start/busy/done handshake and latches the 3-bit opCode. It then drives the datapath's load, accumulate, shift and correction strobes. Multiplies use radix-2 Booth on the 33-bit sign-corrected operands; divides use restoring division on magnitudes, followed by remainder and sign fix-up.

## Interface
- parallelism, 32, operand/result width; the datapath's internal operands are parallelism+1 bits wide.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  operation request; sampled only in IDLE.
- opCode  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- boothPair  in  2  datapath status {q[0], q[-1]} of the multiplier register.
- remNeg  in  1  datapath status: trial remainder (after subtract) is negative.
- divZero  in  1  datapath status: latched divisor equals 0.
- lSign, rSign  in  1 each  MSB of the sign-corrected 33-bit operands, valid from the LOAD cycle onward.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse in DONE; result valid that cycle.
- opLoad  out  1  load the operand registers and clear the accumulator.
- absEn  out  1  replace operands by their magnitudes (signed divides only).
- accAdd, accSub  out  1 each  accumulator add/subtract of the multiplicand or divisor.
- shiftEn  out  1  arithmetic right shift (MUL) or left shift with quotient bit insert (DIV).
- quotBit  out  1  quotient bit to insert, equal to !remNeg.
- restoreEn  out  1  add the divisor back into the remainder.
- negQuot, negRem  out  1 each  two's-complement negate of quotient / remainder in SIGN_FIX.
- resSel  out  2  0 low product, 1 high product, 2 quotient, 3 remainder.
- zeroSel  out  1  force divide-by-zero result: quotient all ones, remainder = dividend.

## Operation
- States: IDLE, LOAD, ABS, MUL_ITER, DIV_ITER, DIV_FIX, SIGN_FIX, DONE.
- IDLE, start=1: latch opCode, then go to LOAD. A start seen in any other state is ignored.
- LOAD: opLoad=1 and the counter is cleared. Next state:
  - opCode[2]=0 goes to MUL_ITER.
  - divZero=1 goes to DONE with zeroSel=1.
  - otherwise goes to ABS.
- MUL_ITER: runs parallelism+1 cycles.
  - boothPair 01 gives accAdd, 10 gives accSub, 00 and 11 give neither.
  - shiftEn=1 every cycle.
  - On the last count, go to DONE.
- ABS: absEn = (opCode==100 or opCode==110). Always lasts one cycle, then go to DIV_ITER.
- DIV_ITER: runs parallelism cycles. accSub=1 and shiftEn=1, quotBit=!remNeg, restoreEn=remNeg, all in the same cycle. On the last count, go to DIV_FIX.
- DIV_FIX: restoreEn=remNeg for the final remainder, then go to SIGN_FIX.
- SIGN_FIX: negQuot = (op 100) & (lSign^rSign); negRem = (op 110) & lSign. Then go to DONE.
- DONE: done=1, resSel driven from the latched opCode, then go to IDLE.
  - MUL gives resSel 0; MULH/MULHSU/MULHU give 1.
  - DIV/DIVU give 2; REM/REMU give 3.
  - zeroSel is held through DONE when entered from the divide-by-zero path.
- Overflow (−2^(parallelism−1) / −1): no special path. The 33-bit magnitude arithmetic yields quotient −2^(parallelism−1) and remainder 0.
- rst=1 at any edge: IDLE and counter 0; any operation in flight is abandoned without done.

## Timing
- Reset values: all outputs 0, state IDLE.
- Every strobe is a decode of registered state; the only combinational paths from inputs to outputs are boothPair/remNeg to the strobes.
- Latency from the accepting edge (start=1 in IDLE) to done:
  - MUL family: parallelism+3 cycles (35).
  - DIV family: parallelism+5 cycles (37).
  - Divide by zero: 2 cycles.
- Latency is independent of operand values.
- Throughput: the next start is accepted no earlier than the cycle after DONE. A start held high through DONE is accepted on the following IDLE edge.
- Counter width is $clog2(parallelism+2). Terminal count is parallelism (MUL) or parallelism−1 (DIV), with no wrap.

## Structure
- Package mdu_pkg holds:
  - opcode enum op_e.
  - state enum state_e.
  - resSel encodings.
  - Helpers is_div(op), is_signed_div(op), is_rem(op).
- Sub-module mdu_iter_counter: clear, enable and terminal-count compare against a runtime limit.

## Test plan
- MUL 7×−3, start for one cycle: done exactly 35 cycles later with resSel=0; the Booth strobe sequence matches the reference model; busy is high for 35 cycles.
- DIV −20/3, then REM −20/3: both finish at cycle 37. DIV gives absEn=1 and negQuot=1 (quotient −6). REM gives negRem=1 (remainder −2).
- DIVU 0xFFFFFFFF/0 with divZero=1: done at cycle 2 with zeroSel=1 and resSel=2; no DIV_ITER strobes.
- DIV 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0; no extra states.
- rst pulsed at iteration 10 of a MUL: outputs 0 the next cycle and no done. A start pulsed mid-DIV is ignored.
- start held high continuously: operations complete every 36 cycles (MUL), with no double accept.
